// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module   : pipe_skid_reg
// Brief    : Two-entry registered valid/ready pipeline stage (main + skid
//            register); in_ready, out_valid and out_data all come from flops.
//            Define PIPE_SKID_FLUSH_EN to add a synchronous flush input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef PIPE_SKID_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  main_q, main_d;
   logic [WIDTH-1:0]  skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              accept;
   logic              pop;

   assign accept = in_valid & in_ready_q;
   assign pop    = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = BUSY;
               main_d  = in_data;
            end
         end
         BUSY: begin
            if (accept && !pop) begin
               state_d = FULL;
               skid_d  = in_data;
            end else if (pop && !accept) begin
               state_d = EMPTY;
            end else if (accept && pop) begin
               main_d  = in_data;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = BUSY;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase

`ifdef PIPE_SKID_FLUSH_EN
      // Flush wins over any handshake; the head word stays visible but invalid.
      if (flush) begin
         state_d = EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
`endif

      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occupancy = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module   : tb_pipe_skid_reg
// Brief    : Self-checking bench for pipe_skid_reg against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       occupancy;

   int n_cmp;
   int n_err;

   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] last_head;

   pipe_skid_reg #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef PIPE_SKID_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
      n_cmp++;
      if (observed !== expected) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic check_model();
      check_val("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
      check_val("in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
      check_val("occupancy", {30'd0, occupancy}, mq.size());
      check_val("out_data",  {16'd0, out_data},  {16'd0, last_head});
   endtask

   // Drive one cycle, advance the model by the handshake rules, check after the edge.
   task automatic tick(input logic v, input logic [WIDTH-1:0] d, input logic r,
                       input logic f);
      bit acc, pp;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      acc = v && (mq.size() < 2);
      pp  = r && (mq.size() > 0);
      if (f) begin
         mq.delete();
      end else begin
         if (pp) void'(mq.pop_front());
         if (acc) mq.push_back(d);
      end
      if (mq.size() > 0) last_head = mq[0];
      @(posedge clk);
      #1;
      check_model();
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      last_head = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'hFFFF;
      rst_n     = 1'b0;

      // Reset with a word offered on the input
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_out_data",  {16'd0, out_data},  32'h0000);
      check_val("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check_val("rst_occupancy", {30'd0, occupancy}, 32'd0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick(1'b0, 16'h0000, 1'b0, 1'b0);
      tick(1'b0, 16'h0000, 1'b0, 1'b0);

      // Single word
      tick(1'b1, 16'h1234, 1'b0, 1'b0);
      check_val("single_data", {16'd0, out_data}, 32'h1234);
      tick(1'b0, 16'h0000, 1'b1, 1'b0);
      check_val("single_pop_valid", {31'd0, out_valid}, 32'd0);
      check_val("single_hold_data", {16'd0, out_data}, 32'h1234);

      // Back-pressure fill then drain in order
      tick(1'b1, 16'hA001, 1'b0, 1'b0);
      tick(1'b1, 16'hA002, 1'b0, 1'b0);
      check_val("bp_full_occ",   {30'd0, occupancy}, 32'd2);
      check_val("bp_full_ready", {31'd0, in_ready},  32'd0);
      check_val("bp_full_data",  {16'd0, out_data},  32'hA001);
      tick(1'b1, 16'hA003, 1'b0, 1'b0);
      check_val("bp_held_off", {16'd0, out_data}, 32'hA001);
      tick(1'b1, 16'hA003, 1'b1, 1'b0);
      check_val("bp_pop2", {16'd0, out_data}, 32'hA002);
      tick(1'b1, 16'hA003, 1'b1, 1'b0);
      check_val("bp_pop3", {16'd0, out_data}, 32'hA003);
      check_val("bp_occ3", {30'd0, occupancy}, 32'd1);
      tick(1'b0, 16'h0000, 1'b1, 1'b0);
      check_val("bp_drained", {31'd0, out_valid}, 32'd0);

      // Streaming at full rate
      tick(1'b1, 16'h0000, 1'b1, 1'b0);
      for (int i = 1; i < 10; i++) begin
         tick(1'b1, 16'(i), 1'b1, 1'b0);
         check_val("stream_data", {16'd0, out_data}, i);
         check_val("stream_occ",  {30'd0, occupancy}, 32'd1);
      end
      tick(1'b0, 16'h0000, 1'b1, 1'b0);

      // Asynchronous reset between edges while full
      tick(1'b1, 16'hA001, 1'b0, 1'b0);
      tick(1'b1, 16'hA002, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("arst_in_ready",  {31'd0, in_ready},  32'd1);
      check_val("arst_occupancy", {30'd0, occupancy}, 32'd0);
      check_val("arst_out_data",  {16'd0, out_data},  32'h0000);
      #1 rst_n = 1'b1;
      mq.delete();
      last_head = '0;
      tick(1'b0, 16'h0000, 1'b1, 1'b0);
      tick(1'b0, 16'h0000, 1'b1, 1'b0);

`ifdef PIPE_SKID_FLUSH_EN
      // Flush while full, with a competing accept and pop
      tick(1'b1, 16'hA001, 1'b0, 1'b0);
      tick(1'b1, 16'hA002, 1'b0, 1'b0);
      tick(1'b1, 16'hBEEF, 1'b1, 1'b1);
      check_val("flush_occ",   {30'd0, occupancy}, 32'd0);
      check_val("flush_valid", {31'd0, out_valid}, 32'd0);
      check_val("flush_data",  {16'd0, out_data},  32'hA001);
      tick(1'b0, 16'h0000, 1'b1, 1'b0);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic f;
         f = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
         f = ($urandom_range(0, 19) == 0);
`endif
         tick(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), f);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
